// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall control: load-use bubbles, I/D-memory wait freezes, branch flush sequencing
// and saturating stall-cycle performance counters.
module hazard_stall_unit #(
  parameter int CNT_W     = 32,
  parameter int DWAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_dest,
  input  logic [4:0]       if_id_src1,
  input  logic [4:0]       if_id_src2,
  input  logic             if_id_use1,
  input  logic             if_id_use2,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             br_taken,
  input  logic             cnt_clear,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic             freeze_back,
  output logic             flush_if_id,
  output logic             dmem_timeout,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt
);

  localparam int DW_W = $clog2(DWAIT_MAX + 1);

  typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, IWAIT = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              pend_flush_q, pend_flush_d;
  logic [CNT_W-1:0]  lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0]  ms_cnt_q, ms_cnt_d;
  logic [DW_W-1:0]   dwait_cnt_q, dwait_cnt_d;

  logic freeze_s, iwait_s, stall_pc_s, stall_if_id_s, bubble_s, flush_s, lu_inc_s;
  logic dmiss_s, imiss_s, load_use_s, timeout_s;

  assign dmiss_s    = dmem_req & ~dmem_resp;
  assign imiss_s    = imem_req & ~imem_resp;
  assign load_use_s = id_ex_mem_read & (id_ex_dest != 5'd0) &
                      ((if_id_use1 & (id_ex_dest == if_id_src1)) |
                       (if_id_use2 & (id_ex_dest == if_id_src2)));

  // Next-state and Mealy stall/flush decode
  always_comb begin
    state_d       = state_q;
    freeze_s      = 1'b0;
    iwait_s       = 1'b0;
    flush_s       = 1'b0;
    lu_inc_s      = 1'b0;
    case (state_q)
      RUN: begin
        if (dmiss_s) begin
          freeze_s = 1'b1;
          state_d  = DWAIT;
        end else if (imiss_s) begin
          iwait_s = 1'b1;
          state_d = IWAIT;
        end else begin
          state_d = RUN;
        end
      end
      DWAIT: begin
        if (!dmem_resp) begin
          freeze_s = 1'b1;
        end else if (imiss_s) begin
          iwait_s = 1'b1;
          state_d = IWAIT;
        end else begin
          state_d = RUN;
        end
      end
      IWAIT: begin
        if (dmiss_s) begin
          freeze_s = 1'b1;
          state_d  = DWAIT;
        end else if (!imem_resp) begin
          iwait_s = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    stall_pc_s    = freeze_s | iwait_s;
    stall_if_id_s = freeze_s;
    bubble_s      = iwait_s;
    // A flush (new or pending) discards the ID instruction, so a load-use stall on it is moot
    if (!freeze_s) begin
      if (br_taken | pend_flush_q) begin
        flush_s  = 1'b1;
        bubble_s = 1'b1;
      end else if (load_use_s) begin
        stall_pc_s    = 1'b1;
        stall_if_id_s = 1'b1;
        bubble_s      = 1'b1;
        lu_inc_s      = 1'b1;
      end else begin
        lu_inc_s = 1'b0;
      end
    end else begin
      flush_s = 1'b0;
    end
  end

  assign timeout_s = (state_q == DWAIT) && (dwait_cnt_q == DW_W'(DWAIT_MAX - 1));

  // Pending flush, counters and DWAIT timer next values
  always_comb begin
    if (freeze_s && br_taken)  pend_flush_d = 1'b1;
    else if (!freeze_s)        pend_flush_d = 1'b0;
    else                       pend_flush_d = pend_flush_q;

    if (state_q == DWAIT && state_d == DWAIT && dwait_cnt_q != DW_W'(DWAIT_MAX))
      dwait_cnt_d = dwait_cnt_q + DW_W'(1);
    else if (state_q == DWAIT && state_d == DWAIT)
      dwait_cnt_d = dwait_cnt_q;
    else
      dwait_cnt_d = '0;

    if (cnt_clear)                          lu_cnt_d = '0;
    else if (lu_inc_s && lu_cnt_q != '1)    lu_cnt_d = lu_cnt_q + CNT_W'(1);
    else                                    lu_cnt_d = lu_cnt_q;

    if (cnt_clear)                                         ms_cnt_d = '0;
    else if ((freeze_s | iwait_s) && ms_cnt_q != '1)       ms_cnt_d = ms_cnt_q + CNT_W'(1);
    else                                                   ms_cnt_d = ms_cnt_q;
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      pend_flush_q <= 1'b0;
      lu_cnt_q     <= '0;
      ms_cnt_q     <= '0;
      dwait_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_flush_q <= pend_flush_d;
      lu_cnt_q     <= lu_cnt_d;
      ms_cnt_q     <= ms_cnt_d;
      dwait_cnt_q  <= dwait_cnt_d;
    end
  end

  assign stall_pc      = rst & stall_pc_s;
  assign stall_if_id   = rst & stall_if_id_s;
  assign bubble_id_ex  = rst & bubble_s;
  assign freeze_back   = rst & freeze_s;
  assign flush_if_id   = rst & flush_s;
  assign dmem_timeout  = rst & timeout_s;
  assign load_use_cnt  = lu_cnt_q;
  assign mem_stall_cnt = ms_cnt_q;

endmodule
